// File: rtl/miriscv_dmem_pkg.sv
// Shared constants and types for the miriscv data-memory responder.
package miriscv_dmem_pkg;

    // MMIO register offsets (word index within the 16-byte window)
    localparam logic [1:0] TOHOST   = 2'd0;
    localparam logic [1:0] CYCLE_LO = 2'd1;
    localparam logic [1:0] CYCLE_HI = 2'd2;
    localparam logic [1:0] PUTC     = 2'd3;

    // Read data returned for addresses outside RAM and MMIO
    localparam logic [31:0] UNMAPPED_RDATA = 32'hDEAD_BEEF;

    // Decoded target of an access
    typedef enum logic [1:0] {
        RAM,
        MMIO,
        UNMAPPED
    } region_e;

endpackage

// File: rtl/miriscv_dmem_mmio.sv
// MMIO register block: cycle counter with high-word shadow, tohost/halt
// latch, character output port and a registered read mux.
module miriscv_dmem_mmio
    import miriscv_dmem_pkg::*;
(
    input  logic        clk_i,
    input  logic        arstn_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic        be0_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        halt_o,
    output logic [31:0] exit_code_o,
    output logic        char_valid_o,
    output logic [7:0]  char_o,
    output logic [63:0] cycle_o
);

    logic [63:0] cycle_q;
    logic [31:0] shadow_q;
    logic        rd;
    logic        wr;

    assign rd      = req_i & ~we_i;
    assign wr      = req_i & we_i;
    assign cycle_o = cycle_q;

    // Free-running 64-bit cycle counter, wraps naturally
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) cycle_q <= '0;
        else          cycle_q <= cycle_q + 64'd1;
    end

    // A CYCLE_LO read snapshots the high word so the following CYCLE_HI read is consistent
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i)                       shadow_q <= '0;
        else if (rd && offset_i == CYCLE_LO) shadow_q <= cycle_q[63:32];
    end

    // First TOHOST write captures the exit code and halts; later writes are ignored
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            halt_o      <= 1'b0;
            exit_code_o <= '0;
        end else if (wr && offset_i == TOHOST && !halt_o) begin
            halt_o      <= 1'b1;
            exit_code_o <= wdata_i;
        end
    end

    // PUTC write with byte lane 0 enabled emits one character pulse
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            char_valid_o <= 1'b0;
            char_o       <= '0;
        end else begin
            char_valid_o <= wr && offset_i == PUTC && be0_i;
            if (wr && offset_i == PUTC && be0_i) char_o <= wdata_i[7:0];
        end
    end

    // Registered read mux; holds its value between MMIO reads
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            rdata_o <= '0;
        end else if (rd) begin
            case (offset_i)
                TOHOST:   rdata_o <= exit_code_o;
                CYCLE_LO: rdata_o <= cycle_q[31:0];
                CYCLE_HI: rdata_o <= shadow_q;
                default:  rdata_o <= '0;
            endcase
        end
    end

endmodule

// File: rtl/miriscv_data_mem.sv
// Data-memory responder for the miriscv core: byte-enable word RAM plus a
// 4-register MMIO window (tohost, cycle lo/hi, putc).
// Optional build macro MIRISCV_DMEM_ERR_EN adds sticky unmapped-access
// error reporting (err_o / err_addr_o).
module miriscv_data_mem
    import miriscv_dmem_pkg::*;
#(
    parameter int unsigned DMEM_WORDS = 1024,
    parameter logic [31:0] DMEM_BASE  = 32'h0000_0000,
    parameter logic [31:0] MMIO_BASE  = 32'h8000_0000
) (
    input  logic        clk_i,
    input  logic        arstn_i,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        halt_o,
    output logic [31:0] exit_code_o,
    output logic        char_valid_o,
    output logic [7:0]  char_o,
`ifdef MIRISCV_DMEM_ERR_EN
    output logic        err_o,
    output logic [31:0] err_addr_o,
`endif
    output logic [63:0] cycle_o
);

    localparam int unsigned AW        = $clog2(DMEM_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(DMEM_WORDS) << 2;

    logic [31:0]   word_addr;
    logic [31:0]   ram_off;
    logic [AW-1:0] ram_idx;
    region_e       region;
    region_e       rsel_q;
    logic          ram_wr;
    logic          mmio_req;
    logic [31:0]   ram_rdata_q;
    logic [31:0]   mmio_rdata;
    logic [31:0]   mem [DMEM_WORDS];
    logic          unused_addr_bits;

    // Address decode on the word-aligned address
    always_comb begin
        word_addr = {data_addr_i[31:2], 2'b00};
        ram_off   = word_addr - DMEM_BASE;
        if (word_addr >= DMEM_BASE && {1'b0, ram_off} < RAM_BYTES) region = RAM;
        else if (word_addr[31:4] == MMIO_BASE[31:4])               region = MMIO;
        else                                                       region = UNMAPPED;
    end

    assign ram_idx          = ram_off[AW+1:2];
    assign unused_addr_bits = ^{data_addr_i[1:0], ram_off[31:AW+2], ram_off[1:0]};
    // Gating on arstn_i drops a write whose edge lands while reset is held
    assign ram_wr           = data_req_i & data_we_i & (region == RAM) & arstn_i;
    assign mmio_req         = data_req_i & (region == MMIO);

    // Byte-enabled RAM write; contents are not reset
    always_ff @(posedge clk_i) begin
        if (ram_wr) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (data_be_i[b]) mem[ram_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
            end
        end
    end

    // Capture RAM read data and remember which source the last read targeted
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            ram_rdata_q <= '0;
            rsel_q      <= RAM;
        end else if (data_req_i && !data_we_i) begin
            rsel_q <= region;
            if (region == RAM) ram_rdata_q <= mem[ram_idx];
        end
    end

    // Final read mux over registered sources, so data_rdata_o holds between reads
    always_comb begin
        case (rsel_q)
            RAM:     data_rdata_o = ram_rdata_q;
            MMIO:    data_rdata_o = mmio_rdata;
            default: data_rdata_o = UNMAPPED_RDATA;
        endcase
    end

    miriscv_dmem_mmio u_mmio (
        .clk_i        (clk_i),
        .arstn_i      (arstn_i),
        .req_i        (mmio_req),
        .we_i         (data_we_i),
        .be0_i        (data_be_i[0]),
        .offset_i     (word_addr[3:2]),
        .wdata_i      (data_wdata_i),
        .rdata_o      (mmio_rdata),
        .halt_o       (halt_o),
        .exit_code_o  (exit_code_o),
        .char_valid_o (char_valid_o),
        .char_o       (char_o),
        .cycle_o      (cycle_o)
    );

`ifdef MIRISCV_DMEM_ERR_EN
    // First unmapped access latches its full address; later ones leave it untouched
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            err_o      <= 1'b0;
            err_addr_o <= '0;
        end else if (data_req_i && region == UNMAPPED && !err_o) begin
            err_o      <= 1'b1;
            err_addr_o <= data_addr_i;
        end
    end
`endif

endmodule
